// File: rtl/sti_frontend_if.sv
// Sample stream, probe input and config bus for sti_frontend.
// The master side is the host/board; the slave side is the front end itself.
interface sti_frontend_if #(
  parameter int unsigned SDW = 32
);
  localparam int unsigned GRP = SDW / 8;

  logic [SDW-1:0] ext_data;
  logic           arm;
  logic           cfg_wr;
  logic [1:0]     cfg_sel;
  logic [31:0]    cfg_data;
  logic           sto_valid;
  logic           sto_ready;
  logic [SDW-1:0] sto_data;
  logic [GRP-1:0] sto_keep;
  logic           overrun;

  modport master (
    output ext_data, arm, cfg_wr, cfg_sel, cfg_data, sto_ready,
    input  sto_valid, sto_data, sto_keep, overrun
  );

  modport slave (
    input  ext_data, arm, cfg_wr, cfg_sel, cfg_data, sto_ready,
    output sto_valid, sto_data, sto_keep, overrun
  );
endinterface

// File: rtl/sti_frontend.sv
// Sample-input front end: synchronise, rate-divide, pack enabled byte groups, stream out.
// Optional per-bit glitch filter behind STI_FRONTEND_GLITCH_FILTER_EN.
module sti_frontend #(
  parameter int unsigned SDW         = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_W       = 24
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  sti_frontend_if.slave bus
);
  localparam int unsigned GRP = SDW / 8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [SDW-1:0] sync_q [SYNC_STAGES];
  logic [SDW-1:0] in_data;
  logic [SDW-1:0] sample_src;
  logic [DIV_W-1:0] div, cnt;
  logic [GRP-1:0] group_en;
  logic           test_mode;
  logic [SDW-1:0] test_cnt;
  logic           start, tick, load, consume;
  logic [SDW-1:0] pack_data;
  logic [GRP-1:0] pack_keep;
  int unsigned    lane;
  logic           unused_cfg;

  assign unused_cfg = ^bus.cfg_data;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.ext_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef STI_FRONTEND_GLITCH_FILTER_EN
  logic [SDW-1:0] filt_q;
  logic [SDW-1:0] sync_diff;

  // A bit follows the synchroniser only once its last two stages agree.
  assign sync_diff = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) filt_q <= '0;
    else            filt_q <= (sync_q[SYNC_STAGES-1] & ~sync_diff) | (filt_q & sync_diff);
  end

  assign in_data = filt_q;
`else
  assign in_data = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    tick      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.arm) begin
          state_nxt = RUN;
          start     = 1'b1;
        end
      end
      RUN: begin
        if (!bus.arm)        state_nxt = IDLE;
        else if (cnt == '0)  tick      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div       <= '0;
      group_en  <= '1;
      test_mode <= 1'b0;
      cnt       <= '0;
      test_cnt  <= '0;
    end else begin
      if (bus.cfg_wr) begin
        case (bus.cfg_sel)
          2'd0: div <= bus.cfg_data[DIV_W-1:0];
          2'd1: begin
            group_en  <= bus.cfg_data[GRP-1:0];
            test_mode <= bus.cfg_data[8];
          end
          default: ;
        endcase
      end
      if (start) begin
        cnt      <= div;
        test_cnt <= '0;
      end else if (state == RUN) begin
        cnt <= (cnt == '0) ? div : cnt - 1'b1;
        if (tick && test_mode) test_cnt <= test_cnt + 1'b1;
      end
    end
  end

  assign sample_src = test_mode ? test_cnt : in_data;

  always_comb begin
    pack_data = '0;
    pack_keep = '0;
    lane      = 0;
    for (int unsigned g = 0; g < GRP; g++) begin
      if (group_en[g]) begin
        pack_data[lane*8 +: 8] = sample_src[g*8 +: 8];
        pack_keep[lane]        = 1'b1;
        lane                   = lane + 1;
      end
    end
  end

  assign load    = tick && (group_en != '0);
  assign consume = bus.sto_valid && bus.sto_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.sto_valid <= 1'b0;
      bus.sto_data  <= '0;
      bus.sto_keep  <= '0;
      bus.overrun   <= 1'b0;
    end else begin
      if (start) bus.overrun <= 1'b0;
      if (load && (!bus.sto_valid || bus.sto_ready)) begin
        bus.sto_data  <= pack_data;
        bus.sto_keep  <= pack_keep;
        bus.sto_valid <= 1'b1;
      end else if (load) begin
        bus.overrun <= 1'b1;
      end else if (consume) begin
        bus.sto_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sti_frontend.sv
// Self-checking bench for sti_frontend: directed scenarios plus a random phase,
// all compared every cycle against a tick-schedule reference model.
module tb_sti_frontend;
  localparam int unsigned SDW  = 32;
  localparam int          S    = 2;
  localparam int          HMSK = 8191;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sti_frontend_if #(.SDW(SDW)) bus();

  sti_frontend #(.SDW(SDW), .SYNC_STAGES(S), .DIV_W(24)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int          e = 16;
  logic [31:0] hist [8192];
  bit          m_run;
  int          next_tick;
  logic [23:0] m_div;
  logic [3:0]  m_ge;
  bit          m_test;
  logic [31:0] m_tc;
  bit          m_valid, m_ovr;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [31:0] m_filt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] src, sync_src, a, b;
    logic [7:0]  lanes[$];
    bit          tk;
    e++;
    if (!rst_n) begin
      hist[e & HMSK] = '0;
      m_run = 0; m_div = '0; m_ge = 4'hF; m_test = 0; m_tc = '0;
      m_valid = 0; m_ovr = 0; m_data = '0; m_keep = '0; m_filt = '0;
      return;
    end
    hist[e & HMSK] = bus.ext_data;
    sync_src = hist[(e - S) & HMSK];
`ifdef STI_FRONTEND_GLITCH_FILTER_EN
    sync_src = m_filt;
    a = hist[(e - S + 1) & HMSK];
    b = hist[(e - S) & HMSK];
    for (int i = 0; i < 32; i++) if (a[i] == b[i]) m_filt[i] = a[i];
`endif
    tk = 0;
    if (!m_run) begin
      if (bus.arm) begin
        m_run = 1; next_tick = e + 1 + int'(m_div); m_tc = '0; m_ovr = 0;
      end
    end else if (!bus.arm) begin
      m_run = 0;
    end else if (e == next_tick) begin
      tk = 1; next_tick = e + int'(m_div) + 1;
    end
    if (tk && m_ge != 4'h0) begin
      src = m_test ? m_tc : sync_src;
      if (!m_valid || bus.sto_ready) begin
        for (int g = 0; g < 4; g++) if (m_ge[g]) lanes.push_back(src[g*8 +: 8]);
        m_data = '0;
        foreach (lanes[j]) m_data = m_data | (32'(lanes[j]) << (8*j));
        m_keep = 4'((1 << lanes.size()) - 1);
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && bus.sto_ready) begin
      m_valid = 0;
    end
    if (tk && m_test) m_tc = m_tc + 1;
    if (bus.cfg_wr) begin
      if (bus.cfg_sel == 2'd0) m_div = bus.cfg_data[23:0];
      else if (bus.cfg_sel == 2'd1) begin
        m_ge = bus.cfg_data[3:0]; m_test = bus.cfg_data[8];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("valid",   bus.sto_valid, m_valid);
    check("overrun", bus.overrun,   m_ovr);
    check("data",    bus.sto_data,  m_data);
    check("keep",    bus.sto_keep,  m_keep);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_sel = sel; bus.cfg_data = d;
    step();
    bus.cfg_wr = 1'b0;
  endtask

  initial begin
    logic [31:0] x, y, held;
    int          cnt_v, hits, lat;
    for (int i = 0; i < 8192; i++) hist[i] = '0;
    bus.ext_data = '0; bus.arm = 0; bus.cfg_wr = 0; bus.cfg_sel = '0;
    bus.cfg_data = '0; bus.sto_ready = 0;

    // reset values
    repeat (4) step();
    #2 rst_n = 1'b1;
    step();
    check("rst_valid", bus.sto_valid, 1'b0);
    check("rst_keep",  bus.sto_keep,  4'h0);
    check("rst_data",  bus.sto_data,  32'h0);

    // test counter, div=0: 0,1,2,3 on consecutive cycles
    cfg_write(2'd1, 32'h0000_010F);
    cfg_write(2'd0, 32'h0);
    bus.sto_ready = 1; bus.arm = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_valid", bus.sto_valid, 1'b1);
      check("t2_data",  bus.sto_data,  32'(i));
      check("t2_keep",  bus.sto_keep,  4'hF);
    end

    // div=3: one valid in every four cycles
    bus.arm = 0; step();
    cfg_write(2'd1, 32'h0000_000F);
    cfg_write(2'd0, 32'd3);
    bus.ext_data = 32'hA1B2C3D4; bus.arm = 1;
    cnt_v = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus.sto_valid) begin
        cnt_v++;
        check("t3_data", bus.sto_data, 32'hA1B2C3D4);
      end
    end
    check("t3_count", cnt_v, 5);

    // sparse group enable packs toward lane 0
    bus.arm = 0; step();
    cfg_write(2'd1, 32'h0000_000A);
    cfg_write(2'd0, 32'd0);
    bus.arm = 1;
    repeat (4) step();
    check("t4_data", bus.sto_data, 32'h0000A1C3);
    check("t4_keep", bus.sto_keep, 4'b0011);
    cfg_write(2'd1, 32'h0);
    step();
    cnt_v = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.sto_valid) cnt_v++;
    end
    check("t4_none", cnt_v, 0);

    // back-pressure: overrun and held sample
    bus.arm = 0; step();
    cfg_write(2'd1, 32'h0000_000F);
    bus.sto_ready = 0;
    x = $urandom; bus.ext_data = x;
    repeat (3) step();
    bus.arm = 1; step();
    step();
    held = bus.sto_data;
    check("t5_first", held, x);
    y = ~x; bus.ext_data = y;
    repeat (3) step();
    check("t5_held", bus.sto_data, x);
    check("t5_ovr",  bus.overrun,  1'b1);
    bus.sto_ready = 1; step();
    check("t5_keepvalid", bus.sto_valid, 1'b1);
    check("t5_new",       bus.sto_data,  y);
    bus.arm = 0; step();
    check("t5_ovr_sticky", bus.overrun, 1'b1);
    bus.arm = 1; step();
    check("t5_ovr_clr", bus.overrun, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.ext_data  = $urandom;
      bus.sto_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) bus.arm = ~bus.arm;
      if ($urandom_range(0, 15) == 0) begin
        bus.cfg_wr  = 1'b1;
        bus.cfg_sel = 2'($urandom_range(0, 3));
        bus.cfg_data = (bus.cfg_sel == 2'd0) ? 32'($urandom_range(0, 4)) : $urandom;
      end
      step();
      bus.cfg_wr = 1'b0;
    end

    // single-cycle glitch on bit 0, then input-to-output latency
    bus.arm = 0; step();
    cfg_write(2'd1, 32'h0000_000F);
    cfg_write(2'd0, 32'h0);
    bus.ext_data = '0; bus.sto_ready = 1; bus.arm = 1;
    repeat (5) step();
    bus.ext_data = 32'h1; step();
    bus.ext_data = 32'h0;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.sto_valid && bus.sto_data[0]) hits++;
    end
`ifdef STI_FRONTEND_GLITCH_FILTER_EN
    check("t6_glitch", hits, 0);
    lat = S + 2;
`else
    check("t6_glitch", hits, 1);
    lat = S + 1;
`endif
    x = $urandom | 32'h0101_0101; bus.ext_data = x;
    for (int i = 1; i < lat; i++) step();
    check("lat_early", (bus.sto_data == x), 1'b0);
    step();
    check("lat_data", bus.sto_data, x);

    // asynchronous reset mid-run, then default group enable visible in keep
    cfg_write(2'd1, 32'h0000_0105);
    bus.sto_ready = 0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    step();
    check("t1_valid", bus.sto_valid, 1'b0);
    check("t1_keep",  bus.sto_keep,  4'h0);
    check("t1_ovr",   bus.overrun,   1'b0);
    bus.arm = 0; bus.ext_data = '0;
    repeat (3) step();
    #2 rst_n = 1'b1;
    step();
    x = $urandom; bus.ext_data = x; bus.sto_ready = 1; bus.arm = 1;
    repeat (4) step();
    check("t1_ge_keep", bus.sto_keep, 4'hF);
    check("t1_ge_data", bus.sto_data, x);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
